// File: rtl/alu_cmd_sequencer_if.sv
// Byte-stream command input and result output bundle for alu_cmd_sequencer.
// The master side feeds command/operand bytes and consumes results; the
// slave side is the sequencer itself.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_flags;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_flags, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_flags, out_valid
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the shared ALU: parses a command byte plus up to two
// operand bytes, holds the operands on the ALU for EXEC_CYCLES cycles, then
// returns result and flags on a valid/ready stream. The last result is kept
// so commands can chain it in as operand A.
module alu_cmd_sequencer #(
    parameter int WIDTH       = 8,
    parameter int NUM_OPS     = 12,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.slave  bus,
    output logic [3:0]          alu_op,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic                alu_start,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic [3:0]          alu_flags,
    output logic                busy,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_RESP
    } state_t;

    localparam logic [3:0] LAST_CNT    = 4'(EXEC_CYCLES - 1);
    localparam logic [4:0] NUM_OPS_LIM = 5'(NUM_OPS);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             chain_q, chain_d;
    logic             unary_q, unary_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             start_q, start_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [3:0]       out_flags_q, out_flags_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             err_q, err_d;

    logic             in_ready;
    logic             accept;
    logic             cmd_illegal;
    logic [WIDTH-1:0] in_word;

    assign in_ready    = (state_q == S_IDLE) || (state_q == S_GET_A) || (state_q == S_GET_B);
    assign accept      = bus.in_valid && in_ready;
    assign cmd_illegal = ({1'b0, bus.in_data[3:0]} >= NUM_OPS_LIM) || (bus.in_data[7:6] != 2'b00);
    assign in_word     = WIDTH'(bus.in_data);

    // Next-state and datapath update: parse bytes, run the EXEC counter, capture the result.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        chain_d     = chain_q;
        unary_d     = unary_q;
        opa_d       = opa_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        start_d     = 1'b0;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        last_d      = last_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        op_d    = bus.in_data[3:0];
                        chain_d = bus.in_data[4];
                        unary_d = bus.in_data[5];
                        if (!bus.in_data[4]) begin
                            state_d = S_GET_A;
                        end else if (!bus.in_data[5]) begin
                            state_d = S_GET_B;
                        end else begin
                            // chain + unary: no operand bytes follow
                            state_d  = S_EXEC;
                            alu_op_d = bus.in_data[3:0];
                            alu_a_d  = last_q;
                            alu_b_d  = '0;
                            start_d  = 1'b1;
                            cnt_d    = '0;
                        end
                    end
                end
            end
            S_GET_A: begin
                if (accept) begin
                    opa_d = in_word;
                    if (unary_q) begin
                        state_d  = S_EXEC;
                        alu_op_d = op_q;
                        alu_a_d  = in_word;
                        alu_b_d  = '0;
                        start_d  = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        state_d = S_GET_B;
                    end
                end
            end
            S_GET_B: begin
                if (accept) begin
                    state_d  = S_EXEC;
                    alu_op_d = op_q;
                    alu_a_d  = chain_q ? last_q : opa_q;
                    alu_b_d  = in_word;
                    start_d  = 1'b1;
                    cnt_d    = '0;
                end
            end
            S_EXEC: begin
                if (cnt_q == LAST_CNT) begin
                    out_data_d  = alu_result;
                    out_flags_d = alu_flags;
                    last_d      = alu_result;
                    cnt_d       = '0;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial command or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            chain_q     <= 1'b0;
            unary_q     <= 1'b0;
            opa_q       <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            start_q     <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_flags_q <= '0;
            last_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            chain_q     <= chain_d;
            unary_q     <= unary_d;
            opa_q       <= opa_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            start_q     <= start_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == S_RESP);
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;
    assign alu_op        = alu_op_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_start     = start_q;
    assign busy          = (state_q != S_IDLE);
    assign err           = err_q;

endmodule
